apb_master: RTL and testbench

Single-outstanding APB initiator that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward one slave. It drives the psel/penable/pwrite/padd/pwdata bus consumed by the team's APB slave peripherals and returns read data and a completion/error status on a one-cycle response strobe. A programmable wait-state timeout keeps a hung slave from locking the initiator.

---
 rtl/apb_master_if.sv | 23 ++
 rtl/apb_master.sv | 136 +++++++++++++
 tb/tb_apb_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// APB bus between a single initiator and one slave.
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] padd;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output psel, penable, pwrite, padd, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, padd, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, SETUP/ACCESS on the bus,
// one-cycle response strobe out, with an optional wait-state timeout.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_master_if.master      bus
);
    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_nxt;
    logic              accept;
    logic              done;
    logic              abort;
    logic              pwrite_q;
    logic [ADDR_W-1:0] padd_q;
    logic [DATA_W-1:0] pwdata_q;

    // Wait-state counter holds at its top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        done         = 1'b0;
        abort        = 1'b0;
        cmd_ready    = 1'b0;
        bus.psel     = 1'b0;
        bus.penable  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !preset;
                if (cmd_valid && !preset) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                bus.psel  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                // A ready slave wins even on the edge the counter would expire.
                if (bus.pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = sat_inc(wait_cnt);
                    if ((TIMEOUT != 0) && (wait_cnt_nxt == CNT_LIM)) begin
                        abort     = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pwrite_q  <= 1'b0;
            padd_q    <= '0;
            pwdata_q  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done || abort;
            if (accept) begin
                pwrite_q <= cmd_write;
                padd_q   <= cmd_addr;
                pwdata_q <= cmd_wdata;
            end
            if (done) begin
                rsp_rdata <= pwrite_q ? '0 : bus.prdata;
                rsp_err   <= 1'b0;
            end else if (abort) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

    assign bus.pwrite = pwrite_q;
    assign bus.padd   = padd_q;
    assign bus.pwdata = pwdata_q;

    a_enable_needs_sel: assert property (@(posedge pclk) disable iff (preset)
        bus.penable |-> bus.psel);
    a_rsp_bus_idle: assert property (@(posedge pclk) disable iff (preset)
        rsp_valid |-> !bus.psel);
    a_addr_stable: assert property (@(posedge pclk) disable iff (preset)
        bus.penable |-> $stable(bus.padd));
endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: cycle-accurate transfer expectations derived from
// command/wait-count rules, with a memory-backed slave and a separate reference memory.
module tb_apb_master;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] slv_mem [256];
    logic [DW-1:0] last_rdata;
    logic          last_err;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic junk_cmd();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_psel", 32'(bus.psel), 32'd0);
            chk("idle_penable", 32'(bus.penable), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_rsp_rdata_hold", 32'(rsp_rdata), 32'(last_rdata));
            chk("idle_rsp_err_hold", 32'(rsp_err), 32'(last_err));
            chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    // Entered with the DUT idle; returns in the response cycle, so consecutive
    // calls issue back-to-back commands.
    task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits);
        int            n;
        bit            err;
        logic [DW-1:0] exp_rd;
        err = (waits >= TO);
        n   = err ? TO : waits + 1;

        chk("accept_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        bus.pready = 1'b0;
        tick();
        acc_cyc = cyc;
        junk_cmd();

        chk("setup_psel", 32'(bus.psel), 32'd1);
        chk("setup_penable", 32'(bus.penable), 32'd0);
        chk("setup_padd", 32'(bus.padd), 32'(a));
        chk("setup_pwrite", 32'(bus.pwrite), 32'(wr));
        chk("setup_pwdata", 32'(bus.pwdata), 32'(d));
        chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();

        for (int k = 0; k < n; k++) begin
            chk("access_psel", 32'(bus.psel), 32'd1);
            chk("access_penable", 32'(bus.penable), 32'd1);
            chk("access_padd", 32'(bus.padd), 32'(a));
            chk("access_pwrite", 32'(bus.pwrite), 32'(wr));
            chk("access_pwdata", 32'(bus.pwdata), 32'(d));
            chk("access_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
            junk_cmd();
            if (k == waits) begin
                bus.pready = 1'b1;
                if (bus.pwrite) begin
                    bus.prdata = 8'($urandom);
                    slv_mem[bus.padd] = bus.pwdata;
                end else begin
                    bus.prdata = slv_mem[bus.padd];
                end
            end else begin
                bus.pready = 1'b0;
                bus.prdata = 8'($urandom);
            end
            tick();
        end

        cmd_valid  = 1'b0;
        bus.pready = 1'b0;
        if (!err && wr) ref_mem[a] = d;
        exp_rd = (err || wr) ? '0 : ref_mem[a];
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_psel", 32'(bus.psel), 32'd0);
        chk("rsp_penable", 32'(bus.penable), 32'd0);
        chk("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        last_rdata = exp_rd;
        last_err   = err;
    endtask

    initial begin
        logic [DW-1:0] v;
        int            a1;
        int            r;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        last_rdata = '0;
        last_err   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            slv_mem[i] = v;
        end
        ref_mem[8'h0C] = 8'h3C;
        slv_mem[8'h0C] = 8'h3C;

        #2 preset = 1'b1;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(bus.psel), 32'd0);
        repeat (2) tick();
        chk("rst_penable", 32'(bus.penable), 32'd0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
        chk("rst_padd", 32'(bus.padd), 32'd0);
        chk("rst_pwdata", 32'(bus.pwdata), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_cmd_ready_held", 32'(cmd_ready), 32'd0);
        preset = 1'b0;
        idle(1);

        do_xfer(1'b1, 8'h05, 8'hA5, 0);
        idle(1);
        do_xfer(1'b0, 8'h0C, 8'h00, 3);
        idle(1);
        do_xfer(1'b0, 8'h05, 8'h00, 4);
        do_xfer(1'b1, 8'h07, 8'h5A, 9);
        do_xfer(1'b0, 8'h05, 8'h00, 1);
        idle(2);

        do_xfer(1'b1, 8'h01, 8'h11, 0);
        a1 = acc_cyc;
        do_xfer(1'b0, 8'h01, 8'h00, 0);
        chk("b2b_spacing", 32'(acc_cyc - a1), 32'd3);
        idle(1);

        for (int it = 0; it < 80; it++) begin
            r = int'($urandom_range(0, 9));
            do_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                    (r < 7) ? (r % 4) : r);
            idle(int'($urandom_range(0, 2)));
        end

        idle(1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h22;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("midrst_in_access", 32'(bus.penable), 32'd1);
        #1 preset = 1'b1;
        #1;
        chk("midrst_psel", 32'(bus.psel), 32'd0);
        chk("midrst_penable", 32'(bus.penable), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) tick();
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("midrst_padd", 32'(bus.padd), 32'd0);
        preset     = 1'b0;
        last_rdata = '0;
        last_err   = 1'b0;
        idle(2);
        do_xfer(1'b0, 8'h0C, 8'h00, 1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
